ss_scan8: RTL and testbench

Eight-digit seven-segment scan driver for the board display. It consumes the four BCD score/time digits from the game counter on `data4`..`data7` and four auxiliary digits on `data0`..`data3`. It time-multiplexes all eight onto the shared active-low anode and segment pins. All eight digits are snapshotted once per scan frame so a counter carry rippling through the digits never tears on the display.

---
 rtl/ss_scan8.sv | 116 +++++++++++
 tb/tb_ss_scan8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ss_scan8.sv
// Eight-digit multiplexed seven-segment driver with per-frame snapshot,
// leading-zero blanking on the top three digits and registered pin outputs.
module ss_scan8 #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [3:0] data2,
  input  logic [3:0] data3,
  input  logic [3:0] data4,
  input  logic [3:0] data5,
  input  logic [3:0] data6,
  input  logic [3:0] data7,
  input  logic [7:0] dp_mask,
  input  logic       blank_lz,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt_reg;
  logic [2:0]    idx_reg;
  logic [3:0]    snap_reg [8];
  logic [7:0]    snap_mask_reg;
  logic          snap_blank_reg;

  logic [31:0]   live_bus;
  logic [3:0]    sel_digit [8];
  logic [7:0]    sel_mask;
  logic          sel_blank;
  logic          load_en;
  logic          term;
  logic          blank7, blank6, blank5;
  logic          digit_blank;
  logic [3:0]    cur_val;
  logic [6:0]    cur_seg;

  assign live_bus = {data7, data6, data5, data4, data3, data2, data1, data0};
  assign term     = (pcnt_reg == PLAST);
  assign load_en  = (idx_reg == 3'd0) && (pcnt_reg == '0);

  // The frame-start cycle shows live inputs so digit 0 matches what is captured.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
      assign sel_digit[gi] = load_en ? live_bus[gi*4 +: 4] : snap_reg[gi];
    end
  endgenerate

  assign sel_mask  = load_en ? dp_mask  : snap_mask_reg;
  assign sel_blank = load_en ? blank_lz : snap_blank_reg;

  assign blank7  = sel_blank && (sel_digit[7] == 4'd0);
  assign blank6  = blank7 && (sel_digit[6] == 4'd0);
  assign blank5  = blank6 && (sel_digit[5] == 4'd0);
  assign cur_val = sel_digit[idx_reg];

  always_comb begin
    digit_blank = 1'b0;
    case (idx_reg)
      3'd7:    digit_blank = blank7;
      3'd6:    digit_blank = blank6;
      3'd5:    digit_blank = blank5;
      default: digit_blank = 1'b0;
    endcase
  end

  always_comb begin
    cur_seg = 7'h3F;
    case (cur_val)
      4'd0:    cur_seg = 7'h40;
      4'd1:    cur_seg = 7'h79;
      4'd2:    cur_seg = 7'h24;
      4'd3:    cur_seg = 7'h30;
      4'd4:    cur_seg = 7'h19;
      4'd5:    cur_seg = 7'h12;
      4'd6:    cur_seg = 7'h02;
      4'd7:    cur_seg = 7'h78;
      4'd8:    cur_seg = 7'h00;
      4'd9:    cur_seg = 7'h10;
      default: cur_seg = 7'h3F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_reg       <= '0;
      idx_reg        <= 3'd0;
      snap_mask_reg  <= 8'h00;
      snap_blank_reg <= 1'b0;
      for (int i = 0; i < 8; i++) snap_reg[i] <= 4'd0;
      an             <= 8'hFF;
      seg            <= 7'h7F;
      dp             <= 1'b1;
      frame_tick     <= 1'b0;
    end else begin
      pcnt_reg <= term ? '0 : pcnt_reg + PW'(1);
      if (term) idx_reg <= idx_reg + 3'd1;
      if (load_en) begin
        for (int i = 0; i < 8; i++) snap_reg[i] <= live_bus[i*4 +: 4];
        snap_mask_reg  <= dp_mask;
        snap_blank_reg <= blank_lz;
      end
      an         <= ~(8'd1 << idx_reg);
      seg        <= digit_blank ? 7'h7F : cur_seg;
      dp         <= digit_blank | ~sel_mask[idx_reg];
      frame_tick <= load_en;
    end
  end

endmodule

// File: tb/tb_ss_scan8.sv
// Bench for ss_scan8: directed scenarios plus random traffic, checked every
// cycle against a frame/slot arithmetic model of the display.
module tb_ss_scan8;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d [8];
  logic [7:0] mask;
  logic       blz;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  ss_scan8 #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .data0      (d[0]),
    .data1      (d[1]),
    .data2      (d[2]),
    .data3      (d[3]),
    .data4      (d[4]),
    .data5      (d[5]),
    .data6      (d[6]),
    .data7      (d[7]),
    .dp_mask    (mask),
    .blank_lz   (blz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         t;
  logic [6:0] seg_tab [16];
  logic [3:0] shown_d [8];
  logic [7:0] shown_mask;
  logic       shown_blz;
  logic [7:0] prev_an;
  int         run_len;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
  endtask

  // t counts cycles since reset release (t=1 is the first free-running cycle).
  // Called at a negedge once this cycle's inputs are in place.
  task automatic cycle();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft, b7, b6, b5, bl;
    int         k, dig;
    if (t == 1) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      k     = (t - 2) % FRAME;
      dig   = k / DIV;
      e_an  = ~(8'd1 << dig);
      b7    = shown_blz && (shown_d[7] == 4'd0);
      b6    = b7 && (shown_d[6] == 4'd0);
      b5    = b6 && (shown_d[5] == 4'd0);
      bl    = (dig == 7 && b7) || (dig == 6 && b6) || (dig == 5 && b5);
      e_seg = bl ? 7'h7F : seg_tab[shown_d[dig]];
      e_dp  = bl ? 1'b1 : ~shown_mask[dig];
      e_ft  = (k == 0);
    end
    chk("an", an, e_an);
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("dp", {7'b0, dp}, {7'b0, e_dp});
    chk("frame_tick", {7'b0, frame_tick}, {7'b0, e_ft});
    chk("an_onehot", {7'b0, (an === 8'hFF) || $onehot(~an)}, 8'd1);
    if (an === prev_an) run_len++;
    else begin
      if (prev_an !== 8'hFF) chk("slot_len", 8'(run_len), 8'(DIV));
      run_len = 1;
      prev_an = an;
    end
    if ((t - 1) % FRAME == 0) begin
      for (int i = 0; i < 8; i++) shown_d[i] = d[i];
      shown_mask = mask;
      shown_blz  = blz;
    end
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic to_frame_start();
    while ((t - 1) % FRAME != 0) cycle();
  endtask

  // Advance until the pins show output slot offset k of a frame.
  task automatic until_out(input int k);
    do cycle(); while (t < 2 || (t - 2) % FRAME != k);
  endtask

  task automatic start_run();
    t       = 1;
    prev_an = 8'hFF;
    run_len = 0;
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
    for (int i = 0; i < 8; i++) shown_d[i] = 4'd0;
    shown_mask = 8'h00;
    shown_blz  = 1'b0;
    t = 0;

    // Reset and first frame: data7..data0 = 1..8
    reset = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = 4'(8 - i);
    mask = 8'h00;
    blz  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'b0, dp}, 8'd1);
    chk("rst_ft", {7'b0, frame_tick}, 8'd0);
    reset = 1'b0;
    start_run();
    cycle();
    chk("first_an", an, 8'hFE);
    chk("first_seg", {1'b0, seg}, 8'h00);
    until_out(4);
    chk("second_seg", {1'b0, seg}, 8'h78);
    until_out(0);

    // Tear-free snapshot on digit 4
    to_frame_start();
    d[4] = 4'd3;
    while ((t - 1) % FRAME != 9) cycle();
    d[4] = 4'd9;
    until_out(17);
    chk("tear_old", {1'b0, seg}, 8'h30);
    until_out(17);
    chk("tear_new", {1'b0, seg}, 8'h10);

    // Leading-zero blanking
    to_frame_start();
    blz = 1'b1;
    d[7] = 4'd0; d[6] = 4'd0; d[5] = 4'd5; d[4] = 4'd0;
    until_out(17);
    chk("blank_d4", {1'b0, seg}, 8'h40);
    until_out(21);
    chk("blank_d5", {1'b0, seg}, 8'h12);
    until_out(25);
    chk("blank_d6", {1'b0, seg}, 8'h7F);
    until_out(29);
    chk("blank_d7", {1'b0, seg}, 8'h7F);
    to_frame_start();
    for (int i = 0; i < 8; i++) d[i] = 4'd0;
    until_out(17);
    chk("zero_d4", {1'b0, seg}, 8'h40);
    until_out(21);
    chk("zero_d5", {1'b0, seg}, 8'h7F);

    // Invalid BCD and decimal point
    to_frame_start();
    blz  = 1'b0;
    d[3] = 4'hC;
    mask = 8'h08;
    until_out(9);
    chk("dp_d2", {7'b0, dp}, 8'd1);
    until_out(13);
    chk("inv_seg", {1'b0, seg}, 8'h3F);
    chk("inv_dp", {7'b0, dp}, 8'd0);

    // Random traffic, including changes on frame-start cycles
    repeat (6 * FRAME) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 8; i++)
          d[i] = (i >= 5 && $urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
        mask = 8'($urandom);
        blz  = 1'($urandom);
      end
      cycle();
    end

    // Reset mid-frame while idx = 5
    while ((t - 1) % FRAME != 21) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    start_run();
    chk("midrst_an", an, 8'hFF);
    chk("midrst_seg", {1'b0, seg}, 8'h7F);
    cycle();
    chk("midrst_d0", an, 8'hFE);

    // Slot length over three frames
    repeat (3 * FRAME) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
